// File: rtl/ddr2_blk_rdwr_pkg.sv
// Shared sizing helpers for the DDR2 block read/write gearbox.
// Width derivations used by the gearbox, its interface and the bench.
package ddr2_blk_rdwr_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   // Bits needed to hold a count 0..max_cnt (never zero wide).
   function automatic int cnt_bits(input int max_cnt);
      return (clog2(max_cnt + 1) < 1) ? 1 : clog2(max_cnt + 1);
   endfunction

   function automatic int acc_bytes(input int in_b, input int out_b);
      return in_b + out_b;
   endfunction

endpackage

// File: rtl/ddr2_blk_rdwr_gearbox_if.sv
// Write-side and show-ahead read-side bundle of the gearbox.
// master drives writes and rd_en; slave is the gearbox.
interface ddr2_blk_rdwr_gearbox_if
   import ddr2_blk_rdwr_pkg::*;
#(
   parameter int IN_BYTES  = 8,
   parameter int OUT_BYTES = 9
);
   localparam int RBW = cnt_bits(OUT_BYTES);

   logic [IN_BYTES*8-1:0]  wr_data;
   logic                   wr_last;
   logic                   wr_en;
   logic                   full;
   logic                   nearly_full;
   logic                   wr_overflow;
   logic                   rd_en;
   logic [OUT_BYTES*8-1:0] rd_data;
   logic [OUT_BYTES*8-1:0] rd_data_d1;
   logic [RBW-1:0]         rd_bytes;
   logic                   rd_last;
   logic                   empty;

   modport master (
      output wr_data, wr_last, wr_en, rd_en,
      input  full, nearly_full, wr_overflow,
      input  rd_data, rd_data_d1, rd_bytes, rd_last, empty
   );

   modport slave (
      input  wr_data, wr_last, wr_en, rd_en,
      output full, nearly_full, wr_overflow,
      output rd_data, rd_data_d1, rd_bytes, rd_last, empty
   );

endinterface

// File: rtl/fallthrough_small_fifo.sv
// Small show-ahead FIFO: dout is valid whenever empty=0.
// Writes while full are ignored; reset is synchronous, active-high.
module fallthrough_small_fifo #(
   parameter int WIDTH          = 72,
   parameter int MAX_DEPTH_BITS = 3
) (
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             nearly_full,
   output logic             empty,
   input  logic             reset,
   input  logic             clk
);
   localparam int DB    = MAX_DEPTH_BITS;
   localparam int DEPTH = 1 << DB;
   localparam logic [DB:0] DEPTH_C = (DB+1)'(DEPTH);
   localparam logic [DB:0] NF_C    = (DB+1)'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DB-1:0]    wr_ptr;
   logic [DB-1:0]    rd_ptr;
   logic [DB:0]      depth;
   logic             wr_ok;
   logic             rd_ok;

   assign full        = (depth == DEPTH_C);
   assign nearly_full = (depth >= NF_C);
   assign empty       = (depth == '0);
   assign dout        = mem[rd_ptr];
   assign wr_ok       = wr_en & ~full;
   assign rd_ok       = rd_en & ~empty;

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         depth  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         depth <= depth + {{DB{1'b0}}, wr_ok} - {{DB{1'b0}}, rd_ok};
      end
   end

endmodule

// File: rtl/ddr2_blk_rdwr_gearbox.sv
// Byte-granular IN_BYTES -> OUT_BYTES width converter with packet tails.
// Bytes sit MSB-aligned in an accumulator; consume and load share a cycle.
module ddr2_blk_rdwr_gearbox
   import ddr2_blk_rdwr_pkg::*;
#(
   parameter int IN_BYTES        = 8,
   parameter int OUT_BYTES       = 9,
   parameter int FIFO_DEPTH_BITS = 2,
   parameter int ACC_BYTES       = acc_bytes(IN_BYTES, OUT_BYTES)
) (
   input  logic clk,
   input  logic rst_n,
   ddr2_blk_rdwr_gearbox_if.slave bus
);
   localparam int IW  = IN_BYTES * 8;
   localparam int OW  = OUT_BYTES * 8;
   localparam int AW  = ACC_BYTES * 8;
   localparam int CW  = cnt_bits(ACC_BYTES);
   localparam int RBW = cnt_bits(OUT_BYTES);

   localparam logic [CW:0] IN_C  = (CW+1)'(IN_BYTES);
   localparam logic [CW:0] OUT_C = (CW+1)'(OUT_BYTES);
   localparam logic [CW:0] ACC_C = (CW+1)'(ACC_BYTES);

   logic [AW-1:0] acc;
   logic [CW-1:0] byte_cnt;
   logic          tail_pend;
   logic [OW-1:0] rd_data_d1_q;
   logic          wr_overflow_q;

   logic [IW:0]   fifo_dout;
   logic          fifo_empty;
   logic          fifo_full;
   logic          fifo_nf;
   logic          fifo_rd;

   logic [CW:0]   cnt_x;
   logic          avail;
   logic          last_c;
   logic [CW:0]   take;
   logic          cons;
   logic [AW-1:0] acc_s;
   logic [CW:0]   cnt_s;
   logic          tail_s;
   logic [AW-1:0] acc_n;
   logic [CW:0]   cnt_n;
   logic          tail_n;
   logic [AW-1:0] word_ext;

   fallthrough_small_fifo #(
      .WIDTH          (IW + 1),
      .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
   ) u_fifo (
      .din         ({bus.wr_last, bus.wr_data}),
      .wr_en       (bus.wr_en),
      .rd_en       (fifo_rd),
      .dout        (fifo_dout),
      .full        (fifo_full),
      .nearly_full (fifo_nf),
      .empty       (fifo_empty),
      .reset       (~rst_n),
      .clk         (clk)
   );

   assign cnt_x    = {1'b0, byte_cnt};
   assign avail    = (cnt_x >= OUT_C) || (tail_pend && (byte_cnt != '0));
   assign last_c   = tail_pend && (cnt_x <= OUT_C);
   assign take     = (cnt_x >= OUT_C) ? OUT_C : cnt_x;
   assign cons     = bus.rd_en & avail;
   assign word_ext = {fifo_dout[IW-1:0], {(AW-IW){1'b0}}};

   // Consume first, then decide the load from the post-consume state.
   always_comb begin
      acc_s  = acc;
      cnt_s  = cnt_x;
      tail_s = tail_pend;
      if (cons) begin
         acc_s = acc << {take, 3'b000};
         cnt_s = cnt_x - take;
         if (last_c) tail_s = 1'b0;
      end
      fifo_rd = !fifo_empty && !tail_s && ((cnt_s + IN_C) <= ACC_C);
      acc_n  = acc_s;
      cnt_n  = cnt_s;
      tail_n = tail_s;
      if (fifo_rd) begin
         acc_n  = acc_s | (word_ext >> {cnt_s, 3'b000});
         cnt_n  = cnt_s + IN_C;
         tail_n = fifo_dout[IW];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc           <= '0;
         byte_cnt      <= '0;
         tail_pend     <= 1'b0;
         rd_data_d1_q  <= '0;
         wr_overflow_q <= 1'b0;
      end else begin
         acc           <= acc_n;
         byte_cnt      <= cnt_n[CW-1:0];
         tail_pend     <= tail_n;
         wr_overflow_q <= bus.wr_en & fifo_full;
         if (cons) rd_data_d1_q <= acc[AW-1 -: OW];
      end
   end

   assign bus.rd_data     = acc[AW-1 -: OW];
   assign bus.rd_bytes    = RBW'(take);
   assign bus.rd_last     = last_c;
   assign bus.empty       = ~avail;
   assign bus.rd_data_d1  = rd_data_d1_q;
   assign bus.full        = fifo_full;
   assign bus.nearly_full = fifo_nf;
   assign bus.wr_overflow = wr_overflow_q;

endmodule

// File: tb/tb_ddr2_blk_rdwr_gearbox.sv
// Directed bench: 64->72 and 72->64 gearboxes with hand-derived outputs.
// Inputs change and outputs are sampled 1 time unit after each clk edge.
module tb_ddr2_blk_rdwr_gearbox;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   ddr2_blk_rdwr_gearbox_if #(.IN_BYTES(8), .OUT_BYTES(9)) b0 ();
   ddr2_blk_rdwr_gearbox_if #(.IN_BYTES(9), .OUT_BYTES(8)) b1 ();

   ddr2_blk_rdwr_gearbox #(
      .IN_BYTES(8), .OUT_BYTES(9), .FIFO_DEPTH_BITS(2)
   ) u0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b0)
   );

   ddr2_blk_rdwr_gearbox #(
      .IN_BYTES(9), .OUT_BYTES(8), .FIFO_DEPTH_BITS(2)
   ) u1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [143:0] obs,
                      input logic [143:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] seq8(input int base);
      logic [63:0] v;
      for (int k = 0; k < 8; k++) v[63-8*k -: 8] = 8'(base + k);
      return v;
   endfunction

   function automatic logic [71:0] seq9(input int base);
      logic [71:0] v;
      for (int k = 0; k < 9; k++) v[71-8*k -: 8] = 8'(base + k);
      return v;
   endfunction

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n = 1'b0;
      b0.wr_data = '0; b0.wr_last = 1'b0; b0.wr_en = 1'b0; b0.rd_en = 1'b0;
      b1.wr_data = '0; b1.wr_last = 1'b0; b1.wr_en = 1'b0; b1.rd_en = 1'b0;
      tick();
      tick();
      chk("rst_empty", b0.empty, 1'b1);
      chk("rst_bytes", b0.rd_bytes, 0);
      chk("rst_last", b0.rd_last, 1'b0);
      chk("rst_data", b0.rd_data, 0);
      chk("rst_d1", b0.rd_data_d1, 0);
      chk("rst_full", b0.full, 1'b0);
      chk("rst_ovf", b0.wr_overflow, 1'b0);
      chk("rst_empty_u1", b1.empty, 1'b1);
      rst_n = 1'b1;
      tick();

      // 64->72 streaming
      b0.wr_data = seq8(0); b0.wr_en = 1'b1; b0.wr_last = 1'b0;
      tick();
      b0.wr_data = seq8(8);
      tick();
      b0.wr_en = 1'b0;
      chk("s_empty_hold", b0.empty, 1'b1);
      tick();
      chk("s_empty_fall", b0.empty, 1'b0);
      chk("s_data0", b0.rd_data, 72'h000102030405060708);
      chk("s_bytes0", b0.rd_bytes, 9);
      chk("s_last0", b0.rd_last, 1'b0);
      b0.rd_en = 1'b1;
      tick();
      b0.rd_en = 1'b0;
      chk("s_d1", b0.rd_data_d1, 72'h000102030405060708);
      chk("s_empty7", b0.empty, 1'b1);
      b0.wr_data = seq8(16); b0.wr_en = 1'b1;
      tick();
      b0.wr_en = 1'b0;
      tick();
      chk("s_data1", b0.rd_data, seq9(9));
      b0.rd_en = 1'b1;
      tick();
      b0.rd_en = 1'b0;
      b0.wr_data = seq8(24); b0.wr_en = 1'b1;
      tick();
      b0.wr_en = 1'b0;
      tick();
      chk("s_data2", b0.rd_data, seq9(18));
      b0.rd_en = 1'b1;
      tick();
      b0.rd_en = 1'b0;
      chk("s_cnt5_empty", b0.empty, 1'b1);

      // reset with 5 bytes held
      rst_n = 1'b0;
      tick();
      chk("r_empty", b0.empty, 1'b1);
      chk("r_d1", b0.rd_data_d1, 0);
      chk("r_bytes", b0.rd_bytes, 0);
      chk("r_data", b0.rd_data, 0);
      chk("r_last", b0.rd_last, 1'b0);
      rst_n = 1'b1;

      // 64->72 tail, following packet waits behind it
      b0.wr_data = 64'h1122334455667788; b0.wr_last = 1'b1; b0.wr_en = 1'b1;
      tick();
      b0.wr_data = 64'hAABBCCDDEEFF0011;
      tick();
      b0.wr_en = 1'b0; b0.wr_last = 1'b0;
      chk("t_empty", b0.empty, 1'b0);
      chk("t_data", b0.rd_data, 72'h112233445566778800);
      chk("t_bytes", b0.rd_bytes, 8);
      chk("t_last", b0.rd_last, 1'b1);
      tick();
      chk("t_hold_data", b0.rd_data, 72'h112233445566778800);
      chk("t_hold_bytes", b0.rd_bytes, 8);
      b0.rd_en = 1'b1;
      tick();
      chk("t_d1", b0.rd_data_d1, 72'h112233445566778800);
      chk("t2_empty", b0.empty, 1'b0);
      chk("t2_data", b0.rd_data, 72'hAABBCCDDEEFF001100);
      chk("t2_bytes", b0.rd_bytes, 8);
      chk("t2_last", b0.rd_last, 1'b1);
      tick();
      b0.rd_en = 1'b0;
      chk("t2_done", b0.empty, 1'b1);

      // 64->72 full packet, rd_en held high
      b0.rd_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i < 9) begin
            b0.wr_data = seq8(8 * i);
            b0.wr_last = (i == 8);
            b0.wr_en   = 1'b1;
         end else begin
            b0.wr_en   = 1'b0;
            b0.wr_last = 1'b0;
         end
         tick();
         chk($sformatf("p_empty%0d", i), b0.empty, !(i >= 2 && i <= 9));
         if (i >= 2 && i <= 9) begin
            chk($sformatf("p_data%0d", i - 2), b0.rd_data, seq9(9 * (i - 2)));
            chk($sformatf("p_bytes%0d", i - 2), b0.rd_bytes, 9);
            chk($sformatf("p_last%0d", i - 2), b0.rd_last, i == 9);
         end
      end
      b0.rd_en = 1'b0;

      // 72->64
      b1.wr_data = 72'hA1A2A3A4A5A6A7A8A9; b1.wr_last = 1'b1; b1.wr_en = 1'b1;
      tick();
      b1.wr_en = 1'b0; b1.wr_last = 1'b0;
      tick();
      chk("n_data0", b1.rd_data, 64'hA1A2A3A4A5A6A7A8);
      chk("n_bytes0", b1.rd_bytes, 8);
      chk("n_last0", b1.rd_last, 1'b0);
      b1.rd_en = 1'b1;
      tick();
      chk("n_data1", b1.rd_data, 64'hA900000000000000);
      chk("n_bytes1", b1.rd_bytes, 1);
      chk("n_last1", b1.rd_last, 1'b1);
      tick();
      b1.rd_en = 1'b0;
      chk("n_empty", b1.empty, 1'b1);

      // backpressure and overflow
      for (int i = 0; i < 7; i++) begin
         b0.wr_data = (i < 6) ? seq8(96 + 8 * i) : 64'hEEEEEEEEEEEEEEEE;
         b0.wr_last = (i == 5);
         b0.wr_en   = 1'b1;
         tick();
         if (i == 4) begin
            chk("o_nf", b0.nearly_full, 1'b1);
            chk("o_not_full", b0.full, 1'b0);
         end
         if (i == 5) begin
            chk("o_full", b0.full, 1'b1);
            chk("o_no_ovf", b0.wr_overflow, 1'b0);
         end
      end
      b0.wr_en = 1'b0; b0.wr_last = 1'b0;
      chk("o_ovf", b0.wr_overflow, 1'b1);
      chk("o_still_full", b0.full, 1'b1);
      tick();
      chk("o_ovf_pulse", b0.wr_overflow, 1'b0);
      b0.rd_en = 1'b1;
      for (int j = 0; j < 6; j++) begin
         chk($sformatf("o_empty%0d", j), b0.empty, 1'b0);
         chk($sformatf("o_data%0d", j), b0.rd_data,
             (j < 5) ? seq9(96 + 9 * j) : 72'h8D8E8F000000000000);
         chk($sformatf("o_bytes%0d", j), b0.rd_bytes, (j < 5) ? 9 : 3);
         chk($sformatf("o_last%0d", j), b0.rd_last, j == 5);
         tick();
      end
      b0.rd_en = 1'b0;
      chk("o_drained", b0.empty, 1'b1);
      chk("o_fifo_free", b0.full, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
